// File: rtl/dht11_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dht11_responder: open-drain DHT11 sensor emulator (ACK + 40-bit frame)|
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module dht11_responder #(
  parameter int START_MIN_CYC = 900000,
  parameter int RESP_DLY_CYC  = 1500,
  parameter int ACK_LOW_CYC   = 4000,
  parameter int ACK_HIGH_CYC  = 4000,
  parameter int BIT_LOW_CYC   = 2500,
  parameter int BIT0_HIGH_CYC = 1350,
  parameter int BIT1_HIGH_CYC = 3500
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic       i_Dht_Line,
  output logic       o_Drive_Low,
  input  logic [7:0] i_Hum_Int,
  input  logic [7:0] i_Hum_Float,
  input  logic [7:0] i_Temp_Int,
  input  logic [7:0] i_Temp_Float,
  input  logic [7:0] i_Crc_Xor,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam logic [23:0] c_start_min = 24'(START_MIN_CYC);
  localparam logic [23:0] c_resp_last = 24'(RESP_DLY_CYC - 1);
  localparam logic [23:0] c_ackl_last = 24'(ACK_LOW_CYC - 1);
  localparam logic [23:0] c_ackh_last = 24'(ACK_HIGH_CYC - 1);
  localparam logic [23:0] c_bitl_last = 24'(BIT_LOW_CYC - 1);
  localparam logic [23:0] c_bit0_last = 24'(BIT0_HIGH_CYC - 1);
  localparam logic [23:0] c_bit1_last = 24'(BIT1_HIGH_CYC - 1);
  localparam logic [5:0]  c_last_bit  = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_LOW = 3'd1,
    S_WAIT_DLY  = 3'd2,
    S_ACK_LOW   = 3'd3,
    S_ACK_HIGH  = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_END_LOW   = 3'd7
  } state_t;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [5:0]  r_bit_idx;
  logic [39:0] r_shift;
  logic        r_line_meta;
  logic        r_line;

  logic [7:0]  w_sum;
  logic [23:0] w_bit_high_last;

  assign w_sum           = 8'(i_Hum_Int + i_Hum_Float + i_Temp_Int + i_Temp_Float);
  assign w_bit_high_last = r_shift[39] ? c_bit1_last : c_bit0_last;

  // Synchronizer resets to the idle-high level so reset never looks like a start.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_line_meta <= 1'b1;
      r_line      <= 1'b1;
    end else begin
      r_line_meta <= i_Dht_Line;
      r_line      <= r_line_meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      o_Drive_Low <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else if (!i_En) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      o_Drive_Low <= 1'b0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_Drive_Low <= 1'b0;
          o_Busy      <= 1'b0;
          if (!r_line) begin
            r_cnt   <= '0;
            r_state <= S_START_LOW;
          end
        end
        S_START_LOW: begin
          if (!r_line) begin
            if (r_cnt < c_start_min) r_cnt <= r_cnt + 24'd1;
          end else if (r_cnt >= c_start_min) begin
            r_shift   <= {i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float,
                          w_sum ^ i_Crc_Xor};
            r_bit_idx <= '0;
            r_cnt     <= '0;
            o_Busy    <= 1'b1;
            r_state   <= S_WAIT_DLY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_DLY: begin
          if (r_cnt == c_resp_last) begin
            r_cnt       <= '0;
            o_Drive_Low <= 1'b1;
            r_state     <= S_ACK_LOW;
          end else r_cnt <= r_cnt + 24'd1;
        end
        S_ACK_LOW: begin
          if (r_cnt == c_ackl_last) begin
            r_cnt       <= '0;
            o_Drive_Low <= 1'b0;
            r_state     <= S_ACK_HIGH;
          end else r_cnt <= r_cnt + 24'd1;
        end
        S_ACK_HIGH: begin
          if (r_cnt == c_ackh_last) begin
            r_cnt       <= '0;
            o_Drive_Low <= 1'b1;
            r_state     <= S_BIT_LOW;
          end else r_cnt <= r_cnt + 24'd1;
        end
        S_BIT_LOW: begin
          if (r_cnt == c_bitl_last) begin
            r_cnt       <= '0;
            o_Drive_Low <= 1'b0;
            r_state     <= S_BIT_HIGH;
          end else r_cnt <= r_cnt + 24'd1;
        end
        S_BIT_HIGH: begin
          // The released width encodes the bit; both exits begin a low phase.
          if (r_cnt == w_bit_high_last) begin
            r_cnt       <= '0;
            r_shift     <= {r_shift[38:0], 1'b0};
            r_bit_idx   <= r_bit_idx + 6'd1;
            o_Drive_Low <= 1'b1;
            r_state     <= (r_bit_idx == c_last_bit) ? S_END_LOW : S_BIT_LOW;
          end else r_cnt <= r_cnt + 24'd1;
        end
        S_END_LOW: begin
          if (r_cnt == c_bitl_last) begin
            r_cnt       <= '0;
            o_Drive_Low <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b1;
            r_state     <= S_IDLE;
          end else r_cnt <= r_cnt + 24'd1;
        end
        default: begin
          r_state     <= S_IDLE;
          o_Drive_Low <= 1'b0;
          o_Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
